paillier_task_scheduler: RTL and testbench
==========================================

# paillier_task_scheduler

Dispatches Paillier tasks (encrypt, decrypt, homomorphic add, scalar multiply) across the BLOCK_COUNT parallel `paillier_top` engines. It sits between the AXI-full front end and the engine array. It picks an idle engine round-robin, pulses that engine's `task_req` with the command, and tracks per-engine busy state. It serialises `task_end` completions into a back-pressured done stream and raises `job_finished` once a programmed number of tasks has retired.

## Interface
Parameters:
- BLOCK_COUNT, 18, number of engines; IDX_W = $clog2(BLOCK_COUNT), minimum 1
- TAG_W, 8, width of the opaque task tag carried from request to completion
- JOB_W, 16, width of the job length and task counters
- TIMEOUT_CYCLES, 65535, watchdog limit per task; used only with the macro

Ports (clock and reset first):
- clk  in  1  single clock for the block
- rst  in  1  reset, synchronous, active-high
- job_start  in  1  pulse; loads job_len and clears the counters; ignored while job_busy=1
- job_len  in  JOB_W  number of tasks in the job
- job_busy  out  1  high from the cycle after an accepted job_start until job_finished
- job_finished  out  1  sticky; cleared by the next accepted job_start
- req_valid  in  1  upstream presents a task
- req_ready  out  1  combinational: job_busy & (issued_cnt < job_len) & (any engine idle)
- req_cmd  in  2  00 encrypt, 01 decrypt, 10 homomorphic add, 11 scalar multiply
- req_tag  in  TAG_W  task tag
- grant_valid  out  1  one-cycle pulse, the cycle after acceptance
- grant_idx  out  IDX_W  engine chosen; upstream steers operands to it
- grant_tag  out  TAG_W  tag of the granted task
- task_req  out  BLOCK_COUNT  one-hot, one-cycle pulse to an engine
- task_cmd  out  2*BLOCK_COUNT  2 bits per engine; engine i uses bits [2i+1:2i]
- task_end  in  BLOCK_COUNT  per-engine completion pulse
- engine_busy  out  BLOCK_COUNT  per-engine busy flag
- done_valid, done_idx (IDX_W), done_tag (TAG_W)  out  completion stream
- done_ready  in  1  completion consumer ready
- timeout_err  out  1  sticky watchdog flag (macro only)
- timeout_idx  out  IDX_W  engine that timed out (macro only)

## Operation
- Per-engine state: IDLE → BUSY on grant; BUSY → PEND on task_end; PEND → IDLE when its completion is popped (done_valid & done_ready).
- Grant arbiter: round-robin over IDLE engines. The search starts at grant_ptr, which advances to (granted index + 1) mod BLOCK_COUNT after each grant.
- Acceptance: a task is accepted when req_valid & req_ready. On acceptance:
  - the engine's cmd and tag registers are stored;
  - issued_cnt increments.
- Done arbiter: independent round-robin pointer over PEND engines. done_idx and done_tag are held stable while done_valid=1 and done_ready=0.
- Completion: done_cnt increments on each pop. When a pop makes done_cnt == job_len:
  - job_finished is set;
  - job_busy is cleared.
- Invalid end: task_end on an engine that is not BUSY is ignored.
- job_len = 0: job_finished is set the cycle after job_start, and no grants occur.
- Counters never wrap; issuance stops at job_len.

## Timing
- Reset values: every output is 0, all engines IDLE, both round-robin pointers 0, all counters 0.
- Reset mid-job: state is discarded. The engines share rst through the top-level reset logic, so no cleanup handshake is needed.
- Grant latency: acceptance at cycle t gives, at t+1:
  - task_req[idx]=1 for exactly one cycle;
  - grant_valid=1;
  - engine_busy[idx]=1.
- task_cmd[idx] is valid from t+1 and held until that engine returns to IDLE.
- Completion latency: task_end at t puts the engine in PEND at t+1; done_valid can assert at t+1.
- Simultaneous task_end on several engines: all are latched as PEND and drained one per cycle.
- A popped engine is IDLE the next cycle and is grantable that cycle.
- Throughput: at most one grant and one completion per cycle, concurrently.

## Configuration
- PAILLIER_SCHED_TIMEOUT_EN defined:
  - each engine has a cycle counter, active while BUSY;
  - when it reaches TIMEOUT_CYCLES, the engine is forced to PEND and emits a completion with its tag;
  - timeout_err is set (sticky until rst or job_start) and timeout_idx is captured (first timeout only).
- Not defined: no counters exist, timeout_err and timeout_idx are tied to 0, and a hung engine stays BUSY indefinitely.

## Test plan
- Reset, then job_start with job_len=3 and BLOCK_COUNT=4; three back-to-back requests with tags 0x10, 0x11, 0x12 -> grant_idx 0, 1, 2 on consecutive cycles, each with a one-cycle task_req, then req_ready=0.
- All 4 engines busy, req_valid held -> req_ready=0. task_end[2], then pop -> the next grant goes to engine 2 one cycle after the pop.
- task_end on engines 1 and 3 in the same cycle, done_ready=0 for 5 cycles -> done_valid stays high with stable idx 1. After release, idx 1 then idx 3 on consecutive cycles.
- job_len=0 -> job_finished=1 the cycle after job_start; no task_req ever asserts. A second job_start while busy -> ignored.
- rst asserted mid-job with 2 engines busy -> the next cycle shows all outputs 0 and engine_busy=0; a new job_len=1 job then completes normally.
- With PAILLIER_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=16, withhold task_end -> after 16 busy cycles done_valid=1 carrying that tag, timeout_err=1, timeout_idx set to that engine.

Source files
------------

// File: rtl/paillier_task_scheduler.sv
// Round-robin task dispatcher for the Paillier engine array, with a back-pressured completion stream.
// Optional per-engine watchdog: define PAILLIER_SCHED_TIMEOUT_EN.
module paillier_task_scheduler #(
  parameter int BLOCK_COUNT    = 18,
  parameter int TAG_W          = 8,
  parameter int JOB_W          = 16,
  parameter int TIMEOUT_CYCLES = 65535,
  localparam int IDX_W = (BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     job_start,
  input  logic [JOB_W-1:0]         job_len,
  output logic                     job_busy,
  output logic                     job_finished,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [1:0]               req_cmd,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     grant_valid,
  output logic [IDX_W-1:0]         grant_idx,
  output logic [TAG_W-1:0]         grant_tag,
  output logic [BLOCK_COUNT-1:0]   task_req,
  output logic [2*BLOCK_COUNT-1:0] task_cmd,
  input  logic [BLOCK_COUNT-1:0]   task_end,
  output logic [BLOCK_COUNT-1:0]   engine_busy,
  output logic                     done_valid,
  output logic [IDX_W-1:0]         done_idx,
  output logic [TAG_W-1:0]         done_tag,
  input  logic                     done_ready,
  output logic                     timeout_err,
  output logic [IDX_W-1:0]         timeout_idx
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_PEND = 2'd2} eng_state_t;

  eng_state_t       state_q [BLOCK_COUNT];
  eng_state_t       state_d [BLOCK_COUNT];
  logic [1:0]       cmd_q   [BLOCK_COUNT];
  logic [1:0]       cmd_d   [BLOCK_COUNT];
  logic [TAG_W-1:0] tag_q   [BLOCK_COUNT];
  logic [TAG_W-1:0] tag_d   [BLOCK_COUNT];

  logic [JOB_W-1:0] job_len_q, job_len_d, issued_cnt_q, issued_cnt_d, done_cnt_q, done_cnt_d;
  logic             job_busy_q, job_busy_d, job_finished_q, job_finished_d;
  logic [IDX_W-1:0] grant_ptr_q, grant_ptr_d, done_ptr_q, done_ptr_d;
  logic             grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
  logic [TAG_W-1:0] grant_tag_q, grant_tag_d;
  logic [BLOCK_COUNT-1:0] task_req_q, task_req_d;
  logic             done_hold_q, done_hold_d;
  logic [IDX_W-1:0] done_sel_q, done_sel_d;

  logic             any_idle, any_pend, job_start_acc, accept, pop;
  logic [IDX_W-1:0] grant_sel, pend_sel;
  logic [BLOCK_COUNT-1:0] timeout_hit;

  function automatic int wrap_add(int base, int off);
    int s = base + off;
    return (s >= BLOCK_COUNT) ? s - BLOCK_COUNT : s;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(logic [IDX_W-1:0] i);
    return (int'(i) == BLOCK_COUNT - 1) ? '0 : i + 1'b1;
  endfunction

  // Two independent round-robin searches: idle engines for grants, pending engines for completions.
  always_comb begin
    any_idle  = 1'b0;
    grant_sel = '0;
    any_pend  = 1'b0;
    pend_sel  = '0;
    for (int k = 0; k < BLOCK_COUNT; k++) begin
      if (!any_idle && state_q[wrap_add(int'(grant_ptr_q), k)] == ST_IDLE) begin
        any_idle  = 1'b1;
        grant_sel = IDX_W'(wrap_add(int'(grant_ptr_q), k));
      end
      if (!any_pend && state_q[wrap_add(int'(done_ptr_q), k)] == ST_PEND) begin
        any_pend = 1'b1;
        pend_sel = IDX_W'(wrap_add(int'(done_ptr_q), k));
      end
    end
  end

  // A stalled completion keeps its index even if newer engines enter PEND ahead of it.
  assign done_valid = any_pend;
  assign done_idx   = done_hold_q ? done_sel_q : pend_sel;
  assign done_tag   = tag_q[done_idx];
  assign req_ready  = job_busy_q & (issued_cnt_q < job_len_q) & any_idle;

  always_comb begin
    job_start_acc  = job_start & ~job_busy_q;
    accept         = req_valid & req_ready;
    pop            = done_valid & done_ready;
    job_len_d      = job_len_q;
    issued_cnt_d   = issued_cnt_q;
    done_cnt_d     = done_cnt_q;
    job_busy_d     = job_busy_q;
    job_finished_d = job_finished_q;
    if (job_start_acc) begin
      job_len_d      = job_len;
      issued_cnt_d   = '0;
      done_cnt_d     = '0;
      job_busy_d     = (job_len != '0);
      job_finished_d = (job_len == '0);
    end else begin
      if (accept) issued_cnt_d = issued_cnt_q + JOB_W'(1);
      if (pop && job_busy_q) begin
        done_cnt_d = done_cnt_q + JOB_W'(1);
        if (done_cnt_q + JOB_W'(1) == job_len_q) begin
          job_finished_d = 1'b1;
          job_busy_d     = 1'b0;
        end
      end
    end

    grant_valid_d = accept;
    grant_idx_d   = grant_idx_q;
    grant_tag_d   = grant_tag_q;
    grant_ptr_d   = grant_ptr_q;
    task_req_d    = '0;
    if (accept) begin
      grant_idx_d = grant_sel;
      grant_tag_d = req_tag;
      grant_ptr_d = next_idx(grant_sel);
    end
    done_ptr_d  = pop ? next_idx(done_idx) : done_ptr_q;
    done_hold_d = done_valid & ~done_ready;
    done_sel_d  = done_idx;

    for (int i = 0; i < BLOCK_COUNT; i++) begin
      state_d[i] = state_q[i];
      cmd_d[i]   = cmd_q[i];
      tag_d[i]   = tag_q[i];
      case (state_q[i])
        ST_IDLE: if (accept && grant_sel == IDX_W'(i)) begin
          state_d[i]    = ST_BUSY;
          cmd_d[i]      = req_cmd;
          tag_d[i]      = req_tag;
          task_req_d[i] = 1'b1;
        end
        ST_BUSY: if (task_end[i] || timeout_hit[i]) state_d[i] = ST_PEND;
        ST_PEND: if (pop && done_idx == IDX_W'(i)) state_d[i] = ST_IDLE;
        default: state_d[i] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      job_len_q      <= '0;
      issued_cnt_q   <= '0;
      done_cnt_q     <= '0;
      job_busy_q     <= 1'b0;
      job_finished_q <= 1'b0;
      grant_ptr_q    <= '0;
      done_ptr_q     <= '0;
      grant_valid_q  <= 1'b0;
      grant_idx_q    <= '0;
      grant_tag_q    <= '0;
      task_req_q     <= '0;
      done_hold_q    <= 1'b0;
      done_sel_q     <= '0;
      for (int i = 0; i < BLOCK_COUNT; i++) begin
        state_q[i] <= ST_IDLE;
        cmd_q[i]   <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      job_len_q      <= job_len_d;
      issued_cnt_q   <= issued_cnt_d;
      done_cnt_q     <= done_cnt_d;
      job_busy_q     <= job_busy_d;
      job_finished_q <= job_finished_d;
      grant_ptr_q    <= grant_ptr_d;
      done_ptr_q     <= done_ptr_d;
      grant_valid_q  <= grant_valid_d;
      grant_idx_q    <= grant_idx_d;
      grant_tag_q    <= grant_tag_d;
      task_req_q     <= task_req_d;
      done_hold_q    <= done_hold_d;
      done_sel_q     <= done_sel_d;
      for (int i = 0; i < BLOCK_COUNT; i++) begin
        state_q[i] <= state_d[i];
        cmd_q[i]   <= cmd_d[i];
        tag_q[i]   <= tag_d[i];
      end
    end
  end

  assign job_busy     = job_busy_q;
  assign job_finished = job_finished_q;
  assign grant_valid  = grant_valid_q;
  assign grant_idx    = grant_idx_q;
  assign grant_tag    = grant_tag_q;
  assign task_req     = task_req_q;

  generate
    for (genvar gi = 0; gi < BLOCK_COUNT; gi++) begin : g_eng
      assign task_cmd[2*gi +: 2] = cmd_q[gi];
      assign engine_busy[gi]     = (state_q[gi] != ST_IDLE);
    end
  endgenerate

`ifdef PAILLIER_SCHED_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic             timeout_err_q, timeout_err_d;
  logic [IDX_W-1:0] timeout_idx_q, timeout_idx_d;

  generate
    for (genvar gi = 0; gi < BLOCK_COUNT; gi++) begin : g_to
      logic [TO_W-1:0] cnt_q, cnt_d;
      assign cnt_d           = (state_q[gi] == ST_BUSY) ? cnt_q + 1'b1 : '0;
      assign timeout_hit[gi] = (state_q[gi] == ST_BUSY) && (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
      always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
      end
    end
  endgenerate

  // Only the first watchdog event of a job is recorded.
  always_comb begin
    timeout_err_d = timeout_err_q;
    timeout_idx_d = timeout_idx_q;
    if (job_start_acc) begin
      timeout_err_d = 1'b0;
      timeout_idx_d = '0;
    end else if (!timeout_err_q && |timeout_hit) begin
      timeout_err_d = 1'b1;
      for (int i = BLOCK_COUNT - 1; i >= 0; i--) begin
        if (timeout_hit[i]) timeout_idx_d = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err_q <= 1'b0;
      timeout_idx_q <= '0;
    end else begin
      timeout_err_q <= timeout_err_d;
      timeout_idx_q <= timeout_idx_d;
    end
  end

  assign timeout_err = timeout_err_q;
  assign timeout_idx = timeout_idx_q;
`else
  assign timeout_hit = '0;
  assign timeout_err = 1'b0;
  assign timeout_idx = '0;
`endif

endmodule

// File: tb/tb_paillier_task_scheduler.sv
// Directed bench for paillier_task_scheduler (4 engines) with grant/completion scoreboards.
module tb_paillier_task_scheduler;
  localparam int BC = 4;
  localparam int IW = 2;
  localparam int TW = 8;
  localparam int JW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          job_start;
  logic [JW-1:0] job_len;
  logic          job_busy, job_finished;
  logic          req_valid, req_ready;
  logic [1:0]    req_cmd;
  logic [TW-1:0] req_tag;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;
  logic [TW-1:0] grant_tag;
  logic [BC-1:0] task_req;
  logic [2*BC-1:0] task_cmd;
  logic [BC-1:0] task_end;
  logic [BC-1:0] engine_busy;
  logic          done_valid;
  logic [IW-1:0] done_idx;
  logic [TW-1:0] done_tag;
  logic          done_ready;
  logic          timeout_err;
  logic [IW-1:0] timeout_idx;

  paillier_task_scheduler #(
    .BLOCK_COUNT(BC), .TAG_W(TW), .JOB_W(JW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .job_start(job_start), .job_len(job_len), .job_busy(job_busy), .job_finished(job_finished),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd), .req_tag(req_tag),
    .grant_valid(grant_valid), .grant_idx(grant_idx), .grant_tag(grant_tag),
    .task_req(task_req), .task_cmd(task_cmd), .task_end(task_end), .engine_busy(engine_busy),
    .done_valid(done_valid), .done_idx(done_idx), .done_tag(done_tag), .done_ready(done_ready),
    .timeout_err(timeout_err), .timeout_idx(timeout_idx)
  );

  always #5 clk = ~clk;

  typedef struct { logic [IW-1:0] idx; logic [TW-1:0] tag; } exp_t;
  exp_t grant_q[$];
  exp_t done_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic exp_t mk(int idx, int tag);
    exp_t e;
    e.idx = IW'(idx);
    e.tag = TW'(tag);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic grant_check();
    exp_t e;
    logic [BC-1:0] oh;
    chk("grant_q_nonempty", grant_q.size() != 0, 1);
    if (grant_q.size() != 0) begin
      e  = grant_q.pop_front();
      oh = BC'(1) << e.idx;
      chk("grant_valid", grant_valid, 1);
      chk("grant_idx", grant_idx, e.idx);
      chk("grant_tag", grant_tag, e.tag);
      chk("task_req", task_req, oh);
      chk("engine_busy_granted", engine_busy[e.idx], 1);
      $display("[TB] grant idx=%0d tag=%02h", grant_idx, grant_tag);
    end
  endtask

  task automatic do_req(input int cmd, input int tag, input int idx);
    req_valid = 1'b1;
    req_cmd   = 2'(cmd);
    req_tag   = TW'(tag);
    #1;
    chk("req_ready", req_ready, 1);
    grant_q.push_back(mk(idx, tag));
    step();
    grant_check();
  endtask

  task automatic pop_done();
    exp_t e;
    done_ready = 1'b1;
    #1;
    chk("done_q_nonempty", done_q.size() != 0, 1);
    if (done_q.size() != 0) begin
      e = done_q.pop_front();
      chk("done_valid", done_valid, 1);
      chk("done_idx", done_idx, e.idx);
      chk("done_tag", done_tag, e.tag);
      $display("[TB] done idx=%0d tag=%02h", done_idx, done_tag);
    end
    step();
    done_ready = 1'b0;
  endtask

  task automatic end_engines(input logic [BC-1:0] mask);
    task_end = mask;
    step();
    task_end = '0;
  endtask

  initial begin
    rst = 1'b1; job_start = 1'b0; job_len = '0; req_valid = 1'b0; req_cmd = '0;
    req_tag = '0; task_end = '0; done_ready = 1'b0;
    repeat (3) step();
    chk("rst_job_busy", job_busy, 0);
    chk("rst_job_finished", job_finished, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_grant_valid", grant_valid, 0);
    chk("rst_grant_idx", grant_idx, 0);
    chk("rst_task_req", task_req, 0);
    chk("rst_task_cmd", task_cmd, 0);
    chk("rst_engine_busy", engine_busy, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;

    // Job A: three back-to-back grants on engines 0,1,2
    job_start = 1'b1; job_len = 16'd3; step(); job_start = 1'b0;
    chk("jobA_busy", job_busy, 1);
    do_req(0, 'h10, 0);
    do_req(1, 'h11, 1);
    do_req(2, 'h12, 2);
    #1; chk("jobA_ready_exhausted", req_ready, 0);
    step();
    chk("jobA_task_req_pulse", task_req, 0);
    chk("jobA_no_grant", grant_valid, 0);
    req_valid = 1'b0;
    chk("jobA_engine_busy", engine_busy, 4'b0111);
    chk("jobA_task_cmd", task_cmd, 8'h24);
    end_engines(4'b1000);
    chk("invalid_end_busy", engine_busy, 4'b0111);
    chk("invalid_end_done", done_valid, 0);
    done_q.push_back(mk(0, 'h10)); done_q.push_back(mk(1, 'h11)); done_q.push_back(mk(2, 'h12));
    end_engines(4'b0111);
    repeat (3) pop_done();
    chk("jobA_finished", job_finished, 1);
    chk("jobA_busy_clr", job_busy, 0);
    chk("jobA_engines_idle", engine_busy, 0);

    // Job B: all engines busy, freed engine regranted, stalled completions
    job_start = 1'b1; job_len = 16'd6; step(); job_start = 1'b0;
    chk("jobB_finished_clr", job_finished, 0);
    do_req(3, 'h20, 3);
    do_req(0, 'h21, 0);
    do_req(1, 'h22, 1);
    do_req(2, 'h23, 2);
    req_cmd = 2'd3; req_tag = 8'h24; #1;
    chk("all_busy_ready", req_ready, 0);
    step();
    chk("all_busy_no_grant", grant_valid, 0);
    chk("all_busy_engines", engine_busy, 4'b1111);
    done_q.push_back(mk(2, 'h23));
    end_engines(4'b0100);
    chk("pend_not_grantable", req_ready, 0);
    pop_done();
    do_req(3, 'h24, 2);
    req_valid = 1'b0;
    chk("regrant_task_cmd", task_cmd, 8'hF4);
    done_q.push_back(mk(3, 'h20));
    end_engines(4'b1000);
    pop_done();
    do_req(1, 'h25, 3);
    req_valid = 1'b0; #1;
    chk("jobB_ready_exhausted", req_ready, 0);
    done_q.push_back(mk(1, 'h22)); done_q.push_back(mk(3, 'h25));
    end_engines(4'b1010);
    for (int c = 0; c < 5; c++) begin
      chk("hold_valid", done_valid, 1);
      chk("hold_idx", done_idx, 1);
      chk("hold_tag", done_tag, 8'h22);
      if (c == 1) begin
        task_end = 4'b0001;
        done_q.push_back(mk(0, 'h21));
      end
      step();
      task_end = '0;
    end
    repeat (3) pop_done();
    chk("jobB_still_busy", job_busy, 1);
    chk("jobB_not_finished", job_finished, 0);
    done_q.push_back(mk(2, 'h24));
    end_engines(4'b0100);
    pop_done();
    chk("jobB_finished", job_finished, 1);
    chk("jobB_busy_clr", job_busy, 0);

    // Job C: a second job_start while busy must not change job_len
    job_start = 1'b1; job_len = 16'd2; step();
    chk("jobC_busy", job_busy, 1);
    chk("jobC_finished_clr", job_finished, 0);
    job_len = 16'd5; step(); job_start = 1'b0;
    do_req(0, 'h30, 0);
    do_req(1, 'h31, 1);
    #1; chk("jobC_len_kept", req_ready, 0);
    req_valid = 1'b0;
    chk("jobC_two_busy", engine_busy, 4'b0011);

    // Reset mid-job
    rst = 1'b1; step();
    chk("midrst_engine_busy", engine_busy, 0);
    chk("midrst_job_busy", job_busy, 0);
    chk("midrst_task_cmd", task_cmd, 0);
    chk("midrst_grant_tag", grant_tag, 0);
    chk("midrst_done_valid", done_valid, 0);
    rst = 1'b0;
    grant_q.delete(); done_q.delete();

    // Zero-length job
    job_start = 1'b1; job_len = 16'd0; step(); job_start = 1'b0;
    chk("len0_finished", job_finished, 1);
    chk("len0_busy", job_busy, 0);
    req_valid = 1'b1; req_tag = 8'h3F;
    for (int c = 0; c < 3; c++) begin
      #1; chk("len0_ready", req_ready, 0);
      step();
      chk("len0_task_req", task_req, 0);
    end
    req_valid = 1'b0;

    // Single-task job after reset
    job_start = 1'b1; job_len = 16'd1; step(); job_start = 1'b0;
    chk("jobD_finished_clr", job_finished, 0);
    do_req(2, 'h40, 0);
    req_valid = 1'b0;
    done_q.push_back(mk(0, 'h40));
    end_engines(4'b0001);
    pop_done();
    chk("jobD_finished", job_finished, 1);
    chk("jobD_busy_clr", job_busy, 0);

`ifdef PAILLIER_SCHED_TIMEOUT_EN
    job_start = 1'b1; job_len = 16'd1; step(); job_start = 1'b0;
    do_req(1, 'h50, 1);
    req_valid = 1'b0;
    begin
      int waited = 0;
      while (!done_valid && waited < 40) begin
        step();
        waited++;
      end
      chk("to_done_valid", done_valid, 1);
      chk("to_busy_cycles", waited, 16);
    end
    chk("to_err", timeout_err, 1);
    chk("to_idx", timeout_idx, 1);
    done_q.push_back(mk(1, 'h50));
    pop_done();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
